// File: rtl/serial_alu_pkg.sv
// Shared definitions for the bit-serial ALU controller.
//   OP_ADD / OP_SUB : encoding of the 1-bit op request field
//   state_t         : controller FSM states
package serial_alu_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_alu_ctrl_if.sv
// Request/response bundle of the serial ALU controller.
//   request  : in_valid, in_ready, op, a, b
//   response : out_valid, out_ready, result, cout, zero, ovf
// master = requester/consumer side, slave = ALU side.
interface serial_alu_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             zero;
  logic             ovf;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, cout, zero, ovf
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, cout, zero, ovf
  );
endinterface

// File: rtl/serial_alu_ctrl_alu1.sv
// ALU1: single-bit full-adder cell.
//   a, b, cin : operand bits and carry in
//   s, cout   : sum bit and carry out
module alu1 (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ADD/SUB controller. One operand bit per cycle, LSB first,
// through a single ALU1 cell. Result is ready WIDTH+1 cycles after accept
// and held until consumed.
//   clk, rst : clock, synchronous active-high reset
//   bus      : request (in_valid/in_ready/op/a/b) and
//              response (out_valid/out_ready/result/cout/zero/ovf)
module serial_alu_ctrl
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  serial_alu_ctrl_if.slave   bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh, b_sh, res_q, res_nxt;
  logic [CW-1:0]    cnt;
  logic             carry, cout_q, zero_q, ovf_q;
  logic             s_bit, c_bit;
  logic             last, in_ready, out_valid;

  alu1 u_alu1 (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (s_bit),
    .cout (c_bit)
  );

  assign last    = (cnt == CW'(WIDTH - 1));
  assign res_nxt = {s_bit, res_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_d = RUN;
      end
      RUN:  if (last) state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        // in_ready is low here, so no accept can share the handshake cycle
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_q  <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          // SUB is a + ~b + 1: invert b and seed the carry with op
          a_sh  <= bus.a;
          b_sh  <= (bus.op == OP_SUB) ? ~bus.b : bus.b;
          carry <= bus.op;
          cnt   <= '0;
        end
        RUN: begin
          res_q <= res_nxt;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= c_bit;
          cnt   <= cnt + 1'b1;
          if (last) begin
            // carry reg still holds the carry into the MSB here
            cout_q <= c_bit;
            ovf_q  <= carry ^ c_bit;
            zero_q <= (res_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.result    = res_q;
  assign bus.cout      = cout_q;
  assign bus.zero      = zero_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Directed + random bench for serial_alu_ctrl at WIDTH=8.
module tb_serial_alu_ctrl;

  typedef struct {
    logic [7:0] r;
    logic       c;
    logic       z;
    logic       v;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   passed = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  serial_alu_ctrl_if #(.WIDTH(8)) bus ();

  serial_alu_ctrl #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic exp_t model(input logic o, input logic [7:0] x, input logic [7:0] y);
    logic [8:0] s;
    exp_t e;
    if (o) begin
      s   = {1'b0, x} - {1'b0, y};
      e.c = ~s[8];
      e.v = (x[7] != y[7]) && (s[7] != x[7]);
    end else begin
      s   = {1'b0, x} + {1'b0, y};
      e.c = s[8];
      e.v = (x[7] == y[7]) && (s[7] != x[7]);
    end
    e.r = s[7:0];
    e.z = (s[7:0] == 8'h00);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input exp_t e);
    chk({tag, "_result"}, 32'(bus.result), 32'(e.r));
    chk({tag, "_cout"},   32'(bus.cout),   32'(e.c));
    chk({tag, "_zero"},   32'(bus.zero),   32'(e.z));
    chk({tag, "_ovf"},    32'(bus.ovf),    32'(e.v));
  endtask

  // Called at a negedge. Issues one op, checks latency and flags, optionally
  // stalls in DONE (pulsing in_valid when pulse=1), then consumes the result.
  task automatic run_op(input logic o, input logic [7:0] x, input logic [7:0] y,
                        input int hold, input bit pulse);
    int   t;
    int   lat;
    exp_t e;
    t = 0;
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.op = o;
    bus.a = x;
    bus.b = y;
    sb.push_back(model(o, x, y));
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a = 8'($urandom);
    bus.b = 8'($urandom);
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'd9);
    e = sb.pop_front();
    chk_out("done", e);
    for (int i = 0; i < hold; i++) begin
      if (pulse) begin
        bus.in_valid = 1'b1;
        bus.op = 1'($urandom);
        bus.a = 8'($urandom);
        bus.b = 8'($urandom);
      end
      @(negedge clk);
      chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      chk_out("hold", e);
    end
    // in pulse mode in_valid stays high through the handshake cycle
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("post_hs_in_ready", 32'(bus.in_ready), 32'd1);
    chk("post_hs_out_valid", 32'(bus.out_valid), 32'd0);
    if (pulse) begin
      bus.in_valid = 1'b0;
      chk_out("post_hs_retain", e);
      @(negedge clk);
      chk("post_hs2_in_ready", 32'(bus.in_ready), 32'd1);
      chk("post_hs2_out_valid", 32'(bus.out_valid), 32'd0);
    end
  endtask

  initial begin
    int   ov_seen;
    exp_t zero_e;
    bus.in_valid  = 1'b0;
    bus.op        = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    zero_e = '{r: 8'h00, c: 1'b0, z: 1'b0, v: 1'b0};

    // reset state
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk_out("rst", zero_e);
    rst = 1'b0;
    @(negedge clk);

    // directed vectors
    run_op(1'b0, 8'h3C, 8'h11, 0, 1'b0);
    run_op(1'b0, 8'hFF, 8'h01, 0, 1'b0);
    run_op(1'b0, 8'h7F, 8'h01, 0, 1'b0);
    run_op(1'b1, 8'h80, 8'h01, 0, 1'b0);
    run_op(1'b1, 8'h05, 8'h05, 0, 1'b0);
    run_op(1'b1, 8'h00, 8'h01, 0, 1'b0);

    // stall in DONE for 5 cycles with in_valid pulsing
    run_op(1'b0, 8'hA5, 8'h3C, 5, 1'b1);

    // reset on the 4th RUN cycle
    bus.in_valid = 1'b1;
    bus.op = 1'b0;
    bus.a = 8'h55;
    bus.b = 8'h22;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrun_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrun_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk_out("midrun_rst", zero_e);
    ov_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.out_valid) ov_seen++;
    end
    chk("midrun_rst_no_result", 32'(ov_seen), 32'd0);
    run_op(1'b0, 8'h01, 8'h02, 0, 1'b0);

    // random back-to-back traffic with random consumer stalls
    for (int n = 0; n < 1000; n++)
      run_op(1'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
